// File: rtl/sm_proto_driver_pkg.sv
// Shared definitions for the handshake initiator: FSM state encoding,
// responder drive vectors, expected responder output codes and small helpers.
package sm_proto_driver_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GO_S1,
        ST_WAIT_S1,
        ST_GO_S2,
        ST_WAIT_S2,
        ST_GO_ID,
        ST_WAIT_ID,
        ST_DONE,
        ST_FAIL,
        ST_REC_KICK,
        ST_REC_WAIT,
        ST_HUNG
    } state_t;

    // Drive vectors on {i1,i2}
    localparam logic [1:0] HOLD_IDLE = 2'b00;
    localparam logic [1:0] PULSE_S1  = 2'b11;
    localparam logic [1:0] PULSE_S2  = 2'b11;
    localparam logic [1:0] HOLD_S1   = 2'b10;
    localparam logic [1:0] HOLD_S2   = 2'b01;
    localparam logic [1:0] PULSE_ID  = 2'b10;
    localparam logic [1:0] REC_PULSE = 2'b01;

    // Expected responder codes on {o1,o2,err}
    localparam logic [2:0] EXP_S1  = 3'b100;
    localparam logic [2:0] EXP_S2  = 3'b010;
    localparam logic [2:0] EXP_ID  = 3'b000;
    localparam logic [2:0] EXP_ERR = 3'b111;

    // Cycles at the start of REC_WAIT whose registered observation still
    // reflects the responder before the recovery kick took effect.
    localparam int unsigned REC_SETTLE = 2;

    function automatic logic [1:0] drive_for(input state_t s);
        case (s)
            ST_GO_S1:    return PULSE_S1;
            ST_WAIT_S1:  return HOLD_S1;
            ST_GO_S2:    return PULSE_S2;
            ST_WAIT_S2:  return HOLD_S2;
            ST_GO_ID:    return PULSE_ID;
            ST_REC_KICK: return REC_PULSE;
            default:     return HOLD_IDLE;
        endcase
    endfunction

    function automatic logic is_wait(input state_t s);
        return (s == ST_WAIT_S1) || (s == ST_WAIT_S2) ||
               (s == ST_WAIT_ID) || (s == ST_REC_WAIT);
    endfunction

endpackage

// File: rtl/sm_proto_driver_if.sv
// Bundles the control-sequencer handshake and the responder bus of the
// initiator.
//   master : the initiator (drives i1/i2 and status, reads start and o1/o2/err)
//   slave  : the surrounding sequencer/responder side
interface sm_proto_driver_if #(
    parameter int unsigned RW = 2
);
    logic          start;
    logic          ready;
    logic          busy;
    logic          done;
    logic          fail;
    logic          hung;
    logic [RW-1:0] retries;
    logic          i1;
    logic          i2;
    logic          o1;
    logic          o2;
    logic          err;

    modport master (
        input  start, o1, o2, err,
        output i1, i2, ready, busy, done, fail, hung, retries
    );

    modport slave (
        output start, o1, o2, err,
        input  i1, i2, ready, busy, done, fail, hung, retries
    );
endinterface

// File: rtl/sm_proto_driver_timer.sv
// Wait-state timeout counter. Counts enabled cycles from zero after a clear
// and saturates at LIMIT, where expired is raised.
//   clk     : clock, rising edge
//   nrst    : synchronous active-low reset
//   clr     : force count to zero
//   en      : count this cycle
//   count   : current count
//   expired : count == LIMIT
module sm_proto_driver_timer #(
    parameter int unsigned W     = 5,
    parameter int unsigned LIMIT = 15
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         expired
);
    assign expired = (count == W'(LIMIT));

    always_ff @(posedge clk) begin
        if (!nrst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/sm_proto_driver.sv
// Initiator for the IDLE/S1/S2/ERROR i1/i2 handshake responder. On start it
// walks the responder IDLE->S1->S2->IDLE, checking each state from the
// registered responder outputs; on err or timeout it issues a recovery kick
// and retries up to RETRY_MAX times.
//   clk  : clock, rising edge
//   nrst : synchronous active-low reset
//   bus  : master side: start in; o1/o2/err in; i1/i2 out (registered);
//          ready, busy, done (pulse), fail (pulse), hung (sticky), retries out
module sm_proto_driver
    import sm_proto_driver_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned TO_W      = 5,
    parameter int unsigned RETRY_MAX = 2,
    parameter int unsigned RW        = 2
) (
    input  logic               clk,
    input  logic               nrst,
    sm_proto_driver_if.master  bus
);
    state_t          state;
    state_t          state_nx;
    logic [2:0]      obs_q;
    logic [1:0]      drv_q;
    logic [RW-1:0]   retries_q;
    logic [RW-1:0]   retries_nx;
    logic [TO_W-1:0] tmr_cnt;
    logic            tmr_exp;
    logic            obs_err;

    // Timer is held clear outside wait states, so it reads zero on the
    // first cycle of every wait state and reaches TIMEOUT-1 on the last.
    sm_proto_driver_timer #(
        .W     (TO_W),
        .LIMIT (TIMEOUT - 1)
    ) u_timer (
        .clk     (clk),
        .nrst    (nrst),
        .clr     (!is_wait(state)),
        .en      (is_wait(state)),
        .count   (tmr_cnt),
        .expired (tmr_exp)
    );

    assign obs_err = obs_q[0];

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            obs_q     <= '0;
            drv_q     <= HOLD_IDLE;
            retries_q <= '0;
        end else begin
            state     <= state_nx;
            obs_q     <= {bus.o1, bus.o2, bus.err};
            // Drive is registered from the next state so it lines up with
            // the state register instead of lagging it by a cycle.
            drv_q     <= drive_for(state_nx);
            retries_q <= retries_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        retries_nx = retries_q;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx   = ST_GO_S1;
                    retries_nx = '0;
                end
            end
            ST_GO_S1: state_nx = ST_WAIT_S1;
            ST_WAIT_S1: begin
                if (obs_err) state_nx = ST_REC_KICK;
                else if (obs_q == EXP_S1) state_nx = ST_GO_S2;
                else if (tmr_exp) state_nx = ST_REC_KICK;
            end
            ST_GO_S2: state_nx = ST_WAIT_S2;
            ST_WAIT_S2: begin
                if (obs_err) state_nx = ST_REC_KICK;
                else if (obs_q == EXP_S2) state_nx = ST_GO_ID;
                else if (tmr_exp) state_nx = ST_REC_KICK;
            end
            ST_GO_ID: state_nx = ST_WAIT_ID;
            ST_WAIT_ID: begin
                if (obs_err) state_nx = ST_REC_KICK;
                else if (obs_q == EXP_ID) state_nx = ST_DONE;
                else if (tmr_exp) state_nx = ST_REC_KICK;
            end
            ST_DONE:     state_nx = ST_IDLE;
            ST_FAIL:     state_nx = ST_IDLE;
            ST_REC_KICK: state_nx = ST_REC_WAIT;
            ST_REC_WAIT: begin
                if (tmr_cnt >= TO_W'(REC_SETTLE) && obs_q == EXP_ID) begin
                    if (retries_q < RW'(RETRY_MAX)) begin
                        state_nx   = ST_GO_S1;
                        retries_nx = retries_q + RW'(1);
                    end else begin
                        state_nx = ST_FAIL;
                    end
                end else if (tmr_exp) begin
                    state_nx = ST_HUNG;
                end
            end
            ST_HUNG: state_nx = ST_HUNG;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus.i1      = drv_q[1];
    assign bus.i2      = drv_q[0];
    assign bus.ready   = (state == ST_IDLE);
    assign bus.busy    = (state != ST_IDLE) && (state != ST_HUNG);
    assign bus.done    = (state == ST_DONE);
    assign bus.fail    = (state == ST_FAIL);
    assign bus.hung    = (state == ST_HUNG);
    assign bus.retries = retries_q;
endmodule

// File: tb/tb_sm_proto_driver.sv
// Directed bench for sm_proto_driver paired with a behavioural
// IDLE/S1/S2/ERROR responder that has fault hooks (state injection,
// freeze, S1 ignoring the advance pulse).
module tb_sm_proto_driver;
    import sm_proto_driver_pkg::*;

    localparam int unsigned TIMEOUT   = 16;
    localparam int unsigned TO_W      = 5;
    localparam int unsigned RETRY_MAX = 2;
    localparam int unsigned RW        = 2;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    sm_proto_driver_if #(.RW(RW)) bus ();

    sm_proto_driver #(
        .TIMEOUT   (TIMEOUT),
        .TO_W      (TO_W),
        .RETRY_MAX (RETRY_MAX),
        .RW        (RW)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    // Behavioural responder
    typedef enum logic [1:0] {R_IDLE, R_S1, R_S2, R_ERR} rstate_t;
    rstate_t    r_state;
    rstate_t    inj_state = R_IDLE;
    logic       inj       = 1'b0;
    logic       freeze    = 1'b0;
    logic       stuck_s1  = 1'b0;
    logic [1:0] drv;

    assign drv = {bus.i1, bus.i2};

    always @(posedge clk) begin
        if (!nrst) r_state <= R_IDLE;
        else if (inj) r_state <= inj_state;
        else if (!freeze) begin
            case (r_state)
                R_IDLE: if (drv == 2'b11) r_state <= R_S1;
                R_S1: begin
                    if (drv == 2'b11 && !stuck_s1) r_state <= R_S2;
                    else if (drv == 2'b01) r_state <= R_IDLE;
                end
                R_S2:  if (drv == 2'b10) r_state <= R_IDLE;
                R_ERR: if (drv == 2'b01) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    function automatic logic [2:0] resp_code(input rstate_t s);
        case (s)
            R_S1:    return EXP_S1;
            R_S2:    return EXP_S2;
            R_ERR:   return EXP_ERR;
            default: return EXP_ID;
        endcase
    endfunction

    assign {bus.o1, bus.o2, bus.err} = resp_code(r_state);

    // Pulse counters
    int done_cnt = 0;
    int fail_cnt = 0;
    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
        if (bus.fail === 1'b1) fail_cnt++;
    end

    int cyc   = 0;
    int t0    = 0;
    int n_cmp = 0;
    int n_mis = 0;
    int d0    = 0;
    int f0    = 0;

    logic [1:0] seq1 [9] = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc - t0);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Advance to cycle start-edge + k of the current transaction.
    task automatic at(input int k);
        while (cyc < t0 + k) tick(1);
    endtask

    task automatic kick();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        t0 = cyc;
    endtask

    initial begin
        bus.start = 1'b0;
        tick(2);
        check("rst_ready",   32'(bus.ready),   1);
        check("rst_busy",    32'(bus.busy),    0);
        check("rst_drv",     32'(drv),         0);
        check("rst_done",    32'(bus.done),    0);
        check("rst_hung",    32'(bus.hung),    0);
        check("rst_retries", 32'(bus.retries), 0);
        nrst = 1'b1;
        tick(1);

        // 1: nominal transaction
        kick();
        for (int k = 0; k < 9; k++) begin
            at(k);
            check("t1_drv",    32'(drv),      32'(seq1[k]));
            check("t1_nodone", 32'(bus.done), 0);
        end
        at(9);
        check("t1_done",    32'(bus.done),    1);
        check("t1_fail",    32'(bus.fail),    0);
        check("t1_retries", 32'(bus.retries), 0);
        at(10);
        check("t1_done_end", 32'(bus.done),  0);
        check("t1_ready",    32'(bus.ready), 1);

        // 2: responder forced to ERROR during WAIT_S2
        kick();
        at(3);
        check("t2_go_s2", 32'(drv), 32'(2'b11));
        inj_state = R_ERR;
        inj = 1'b1;
        tick(1);
        inj = 1'b0;
        at(6);
        check("t2_kick",     32'(drv),      32'(2'b01));
        at(7);
        check("t2_recwait",  32'(drv),      0);
        at(9);
        check("t2_nodone",   32'(bus.done), 0);
        check("t2_busy",     32'(bus.busy), 1);
        at(10);
        check("t2_retry_go", 32'(drv),         32'(2'b11));
        check("t2_retries",  32'(bus.retries), 1);
        at(18);
        check("t2_nodone2",  32'(bus.done),    0);
        at(19);
        check("t2_done",     32'(bus.done),    1);
        check("t2_retries2", 32'(bus.retries), 1);
        at(20);

        // 3: responder stuck in S1, retries exhausted
        stuck_s1 = 1'b1;
        d0 = done_cnt;
        f0 = fail_cnt;
        kick();
        at(19);
        check("t3_wait_s2",  32'(drv),         32'(2'b01));
        at(21);
        check("t3_timeout",  32'(drv),         0);
        at(24);
        check("t3_retry1",   32'(drv),         32'(2'b11));
        check("t3_retries1", 32'(bus.retries), 1);
        at(48);
        check("t3_retry2",   32'(drv),         32'(2'b11));
        check("t3_retries2", 32'(bus.retries), 2);
        at(71);
        check("t3_nofail",   32'(bus.fail),    0);
        at(72);
        check("t3_fail",     32'(bus.fail),    1);
        check("t3_retries",  32'(bus.retries), 2);
        at(73);
        check("t3_fail_end", 32'(bus.fail),    0);
        check("t3_ready",    32'(bus.ready),   1);
        check("t3_fail_cnt", 32'(fail_cnt - f0), 1);
        check("t3_done_cnt", 32'(done_cnt - d0), 0);
        stuck_s1 = 1'b0;

        // 4: responder frozen at S2 -> recovery never sees IDLE -> hung
        inj_state = R_S2;
        inj = 1'b1;
        tick(1);
        inj = 1'b0;
        freeze = 1'b1;
        kick();
        at(17);
        check("t4_kick",     32'(drv),         32'(2'b01));
        at(33);
        check("t4_nohung",   32'(bus.hung),    0);
        check("t4_busy",     32'(bus.busy),    1);
        at(34);
        check("t4_hung",     32'(bus.hung),    1);
        check("t4_idle_bsy", 32'(bus.busy),    0);
        check("t4_ready",    32'(bus.ready),   0);
        check("t4_retries",  32'(bus.retries), 0);
        bus.start = 1'b1;
        tick(3);
        bus.start = 1'b0;
        check("t4_hung_st",  32'(bus.hung),    1);
        check("t4_drv",      32'(drv),         0);
        check("t4_busy_st",  32'(bus.busy),    0);
        nrst = 1'b0;
        tick(1);
        check("t4_rst_hung",  32'(bus.hung),  0);
        check("t4_rst_ready", 32'(bus.ready), 1);
        check("t4_rst_busy",  32'(bus.busy),  0);
        check("t4_rst_drv",   32'(drv),       0);
        check("t4_rst_fail",  32'(bus.fail),  0);
        nrst = 1'b1;
        freeze = 1'b0;
        tick(1);

        // 5: start held high through a transaction and its DONE cycle
        d0 = done_cnt;
        bus.start = 1'b1;
        tick(1);
        t0 = cyc;
        at(5);
        check("t5_drv",      32'(drv),      32'(2'b01));
        check("t5_busy",     32'(bus.busy), 1);
        at(9);
        check("t5_done",     32'(bus.done), 1);
        bus.start = 1'b0;
        at(10);
        check("t5_ready",    32'(bus.ready), 1);
        at(11);
        check("t5_ready2",   32'(bus.ready), 1);
        check("t5_idle_drv", 32'(drv),       0);
        check("t5_done_cnt", 32'(done_cnt - d0), 1);

        // 6: reset during WAIT_S1, then a fresh transaction
        kick();
        at(1);
        check("t6_wait_s1", 32'(drv), 32'(2'b10));
        nrst = 1'b0;
        tick(1);
        check("t6_rst_drv",   32'(drv),       0);
        check("t6_rst_busy",  32'(bus.busy),  0);
        check("t6_rst_ready", 32'(bus.ready), 1);
        nrst = 1'b1;
        tick(1);
        kick();
        at(8);
        check("t6_nodone",  32'(bus.done),    0);
        at(9);
        check("t6_done",    32'(bus.done),    1);
        check("t6_retries", 32'(bus.retries), 0);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
